switch_input_conditioner: RTL and testbench

Parametrised N-channel front end for the board push-buttons. It replaces the per-switch debounce instance plus the hand-copied edge/toggle logic in the top level. Per channel it provides:
- metastability synchronisation
- debounce
- press and release pulses
- a toggle state
- auto-repeat pulses while a button is held
Outputs feed game logic (paddle control) and the LEDs directly; all channels are fully independent.

---
 rtl/switch_input_conditioner.sv | 153 +++++++++++++++
 tb/tb_switch_input_conditioner.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input_conditioner.sv
// switch_input_conditioner: N independent push-button channels.
// Each channel synchronises, debounces, and produces press and release pulses,
// a toggle bit, and auto-repeat pulses while the button is held.
//
// Ports:
//   i_Clk      system clock
//   i_Reset    synchronous, active-high reset
//   i_Switch   raw asynchronous switch inputs (1 = pressed)
//   o_Level    debounced level
//   o_Press    1-cycle pulse on debounced 0->1
//   o_Release  1-cycle pulse on debounced 1->0
//   o_Toggle   flips on every press
//   o_Repeat   1-cycle auto-repeat pulses while held (tied 0 if REPEAT_DELAY == 0)
module switch_input_conditioner #(
  parameter int unsigned NUM_SWITCHES   = 4,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned REPEAT_DELAY   = 12500000,
  parameter int unsigned REPEAT_RATE    = 2500000
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  output logic [NUM_SWITCHES-1:0] o_Level,
  output logic [NUM_SWITCHES-1:0] o_Press,
  output logic [NUM_SWITCHES-1:0] o_Release,
  output logic [NUM_SWITCHES-1:0] o_Toggle,
  output logic [NUM_SWITCHES-1:0] o_Repeat
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_LIMIT + 1);

  logic [NUM_SWITCHES-1:0] sync_meta;
  logic [NUM_SWITCHES-1:0] sync_q;

  // Two-flop synchroniser for the raw inputs
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= i_Switch;
      sync_q    <= sync_meta;
    end
  end

  genvar ch;
  generate
    for (ch = 0; ch < NUM_SWITCHES; ch++) begin : g_ch
      logic [DB_W-1:0] db_cnt;
      logic [DB_W-1:0] db_cnt_next;
      logic            level_q, level_next;
      logic            press_q, press_next;
      logic            release_q, release_next;
      logic            toggle_q, toggle_next;

      // Debounce: accept the synchronised value once it has differed from
      // the current level for DEBOUNCE_LIMIT consecutive cycles
      always_comb begin
        db_cnt_next  = db_cnt;
        level_next   = level_q;
        press_next   = 1'b0;
        release_next = 1'b0;
        toggle_next  = toggle_q;
        if (sync_q[ch] == level_q) begin
          db_cnt_next = '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_LIMIT - 1)) begin
          db_cnt_next  = '0;
          level_next   = sync_q[ch];
          press_next   = sync_q[ch];
          release_next = ~sync_q[ch];
          if (sync_q[ch]) begin
            toggle_next = ~toggle_q;
          end
        end else begin
          db_cnt_next = db_cnt + DB_W'(1);
        end
      end

      always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
          db_cnt    <= '0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          toggle_q  <= 1'b0;
        end else begin
          db_cnt    <= db_cnt_next;
          level_q   <= level_next;
          press_q   <= press_next;
          release_q <= release_next;
          toggle_q  <= toggle_next;
        end
      end

      assign o_Level[ch]   = level_q;
      assign o_Press[ch]   = press_q;
      assign o_Release[ch] = release_q;
      assign o_Toggle[ch]  = toggle_q;

      if (REPEAT_DELAY == 0) begin : g_no_repeat
        assign o_Repeat[ch] = 1'b0;
      end else begin : g_repeat
        localparam int unsigned HOLD_MAX =
          (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
        localparam int unsigned HW = $clog2(HOLD_MAX + 1);
        localparam logic [0:0] WAIT_DELAY = 1'b0;
        localparam logic [0:0] REPEATING  = 1'b1;

        logic [HW-1:0] hold_cnt, hold_cnt_next;
        logic [0:0]    phase_q, phase_next;
        logic          repeat_q, repeat_next;

        // Hold timer; idles while released, and a release edge clears it
        // without emitting a pulse alongside the falling level
        always_comb begin
          hold_cnt_next = hold_cnt;
          phase_next    = phase_q;
          repeat_next   = 1'b0;
          if (!level_q || release_next) begin
            hold_cnt_next = '0;
            phase_next    = WAIT_DELAY;
          end else if (phase_q == WAIT_DELAY &&
                       hold_cnt == HW'(REPEAT_DELAY - 1)) begin
            repeat_next   = 1'b1;
            hold_cnt_next = '0;
            phase_next    = REPEATING;
          end else if (phase_q == REPEATING &&
                       hold_cnt == HW'(REPEAT_RATE - 1)) begin
            repeat_next   = 1'b1;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt + HW'(1);
          end
        end

        always_ff @(posedge i_Clk) begin
          if (i_Reset) begin
            hold_cnt <= '0;
            phase_q  <= WAIT_DELAY;
            repeat_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt_next;
            phase_q  <= phase_next;
            repeat_q <= repeat_next;
          end
        end

        assign o_Repeat[ch] = repeat_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Bench for switch_input_conditioner: directed scenarios with literal
// expectations plus randomised stimulus, all checked every cycle against a
// behavioural model of the debounce/press/toggle/repeat rules.
module tb_switch_input_conditioner;
  localparam int NS = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] sw;
  logic [NS-1:0] level, press, rel, tog, rep;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  switch_input_conditioner #(
    .NUM_SWITCHES(NS), .DEBOUNCE_LIMIT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Switch(sw),
    .o_Level(level), .o_Press(press), .o_Release(rel),
    .o_Toggle(tog), .o_Repeat(rep)
  );

  // ---------------- behavioural model ----------------
  bit            model_on = 1'b0;
  logic [NS-1:0] m_level, m_press, m_release, m_toggle, m_repeat;
  logic [NS-1:0] samp[$];       // raw samples, newest first (2-edge delay line)
  logic [NS-1:0] seen_win[DB];  // last DB synchronised values, newest at 0
  logic [NS-1:0] seen;
  int            seen_cnt;
  int            cyc;
  int            press_cyc[NS];
  bit            press_valid[NS];
  bit            flip;
  int            d;

  initial forever begin
    @(posedge clk);
    if (rst === 1'b1) begin
      model_on  = 1'b1;
      m_level   = '0; m_press = '0; m_release = '0; m_toggle = '0; m_repeat = '0;
      samp.delete(); samp.push_back('0); samp.push_back('0);
      seen_cnt  = 0;
      cyc       = 0;
      for (int c = 0; c < NS; c++) begin
        press_valid[c] = 1'b0;
        press_cyc[c]   = 0;
      end
    end else if (model_on) begin
      seen = samp[1];
      samp.push_front(sw);
      void'(samp.pop_back());
      for (int k = DB - 1; k > 0; k--) seen_win[k] = seen_win[k-1];
      seen_win[0] = seen;
      if (seen_cnt < DB) seen_cnt++;
      cyc++;
      for (int c = 0; c < NS; c++) begin
        // level flips once the last DB synchronised samples all disagree with it
        flip = (seen_cnt >= DB);
        for (int k = 0; k < DB; k++)
          if (seen_win[k][c] == m_level[c]) flip = 1'b0;
        m_press[c]   = flip && !m_level[c];
        m_release[c] = flip && m_level[c];
        if (flip) m_level[c] = ~m_level[c];
        if (m_press[c]) begin
          m_toggle[c]    = ~m_toggle[c];
          press_cyc[c]   = cyc;
          press_valid[c] = 1'b1;
        end
        d = cyc - press_cyc[c];
        m_repeat[c] = m_level[c] && press_valid[c] && d >= RD && ((d - RD) % RR) == 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  int press_seen[NS];
  int rel_seen[NS];

  initial begin
    for (int c = 0; c < NS; c++) begin press_seen[c] = 0; rel_seen[c] = 0; end
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("level",   level, m_level);
        check("press",   press, m_press);
        check("release", rel,   m_release);
        check("toggle",  tog,   m_toggle);
        check("repeat",  rep,   m_repeat);
        for (int c = 0; c < NS; c++) begin
          if (press[c] === 1'b1) press_seen[c]++;
          if (rel[c] === 1'b1)   rel_seen[c]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int ch, input bit rel_sel, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = rel_sel ? (rel[ch] === 1'b1) : (press[ch] === 1'b1);
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL wait_%s ch%0d actual=none required=pulse within %0d cycles",
               rel_sel ? "release" : "press", ch, budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  int            rep_list[$];
  int            exp_off[7] = '{10, 13, 16, 19, 22, 25, 28};
  int            p_snap, r_snap, rep_after, i0, i3;
  logic [7:0]    bounce = 8'b0111_0111;
  int            hold[NS];

  initial begin
    // 1: reset held 3 cycles with all switches pressed
    rst = 1'b1; sw = 4'b1111;
    step(); step(); step();
    check("s1_rst_level", level, 4'b0000);
    check("s1_rst_toggle", tog, 4'b0000);
    rst = 1'b0;
    repeat (5) step();
    check("s1_level_edge5", level, 4'b0000);
    step();
    check("s1_level_edge6", level, 4'b1111);
    check("s1_press_edge6", press, 4'b1111);
    check("s1_toggle_edge6", tog, 4'b1111);
    step();
    check("s1_press_edge7", press, 4'b0000);
    sw = '0;
    repeat (12) step();

    // 2: ch0 clean step then release
    do_reset();
    sw[0] = 1'b1;
    repeat (5) step();
    check_int("s2_level_edge5", int'(level[0]), 0);
    step();
    check_int("s2_level_edge6", int'(level[0]), 1);
    check_int("s2_press_edge6", int'(press[0]), 1);
    check_int("s2_toggle_on", int'(tog[0]), 1);
    step();
    check_int("s2_press_edge7", int'(press[0]), 0);
    repeat (10) step();
    sw[0] = 1'b0;
    repeat (5) step();
    check_int("s2_rel_edge5", int'(rel[0]), 0);
    step();
    check_int("s2_rel_edge6", int'(rel[0]), 1);
    check_int("s2_toggle_kept", int'(tog[0]), 1);
    step();
    check_int("s2_rel_edge7", int'(rel[0]), 0);

    // 3: ch1 bounce never qualifies
    p_snap = press_seen[1];
    for (int i = 0; i < 8; i++) begin sw[1] = bounce[i]; step(); end
    repeat (10) step();
    check_int("s3_press_count", press_seen[1] - p_snap, 0);
    check_int("s3_toggle", int'(tog[1]), 0);
    check_int("s3_level", int'(level[1]), 0);

    // 4: ch2 held, auto-repeat timing relative to the press cycle
    sw[2] = 1'b1;
    wait_pulse(2, 1'b0, 20);
    check_int("s4_repeat_in_press_cycle", int'(rep[2]), 0);
    for (int off = 1; off <= 30; off++) begin
      step();
      if (rep[2] === 1'b1) rep_list.push_back(off);
    end
    sw[2] = 1'b0;
    check_int("s4_repeat_count", rep_list.size(), 7);
    for (int i = 0; i < 7 && i < rep_list.size(); i++)
      check_int($sformatf("s4_repeat_off%0d", i), rep_list[i], exp_off[i]);
    wait_pulse(2, 1'b1, 20);
    rep_after = 0;
    for (int i = 0; i < 15; i++) begin
      if (rep[2] === 1'b1) rep_after++;
      step();
    end
    check_int("s4_repeat_after_release", rep_after, 0);

    // 5: ch3 pressed twice
    do_reset();
    p_snap = press_seen[3]; r_snap = rel_seen[3];
    sw[3] = 1'b1;
    wait_pulse(3, 1'b0, 20);
    check_int("s5_toggle_first", int'(tog[3]), 1);
    repeat (3) step();
    sw[3] = 1'b0;
    wait_pulse(3, 1'b1, 20);
    repeat (3) step();
    sw[3] = 1'b1;
    wait_pulse(3, 1'b0, 20);
    check_int("s5_toggle_second", int'(tog[3]), 0);
    sw[3] = 1'b0;
    wait_pulse(3, 1'b1, 20);
    repeat (3) step();
    check_int("s5_press_count", press_seen[3] - p_snap, 2);
    check_int("s5_release_count", rel_seen[3] - r_snap, 2);

    // 6: ch0+ch3 together while ch1 bounces, then reset mid-repeat
    repeat (5) step();
    p_snap = press_seen[1];
    i0 = -1; i3 = -1;
    sw[0] = 1'b1; sw[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sw[1] = bounce[i];
      step();
      if (press[0] === 1'b1) i0 = i;
      if (press[3] === 1'b1) i3 = i;
    end
    check_int("s6_press_ch0_step", i0, 5);
    check_int("s6_press_ch3_step", i3, 5);
    repeat (10) step();
    check_int("s6_ch1_press_count", press_seen[1] - p_snap, 0);
    check_int("s6_ch1_level", int'(level[1]), 0);
    rst = 1'b1;
    step();
    check_int("s6_rst_repeat", int'(rep[0]), 0);
    check_int("s6_rst_level", int'(level[0]), 0);
    check_int("s6_rst_toggle", int'(tog[0]), 0);
    rst = 1'b0;
    repeat (6) step();
    check_int("s6_repress", int'(press[0]), 1);
    check_int("s6_repress_toggle", int'(tog[0]), 1);

    // Randomised phase: mix of glitches and long holds, occasional reset
    for (int c = 0; c < NS; c++) hold[c] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NS; c++) begin
        if (hold[c] == 0) begin
          sw[c]   = ~sw[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                 : int'($urandom_range(4, 40));
        end else begin
          hold[c]--;
        end
      end
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
